fifo_wr_ctrl: RTL

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_wr_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of a dual-clock FIFO: accepts words, drives the memory write port,
// keeps the Gray write pointer and derives full/almost_full/occupancy from the synchronised read pointer.
module fifo_wr_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int PTR_WIDTH  = 8,
   parameter int AF_GAP     = 4
) (
   input  logic                  wr_clk,
   input  logic                  wr_rst_n,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_din,
   output logic                  wr_ready,
   input  logic [PTR_WIDTH:0]    rd_ptr_gray,
   output logic                  mem_wr_en,
   output logic [PTR_WIDTH-1:0]  mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic [PTR_WIDTH:0]    wr_ptr_gray,
   output logic                  full,
   output logic                  almost_full,
   output logic [PTR_WIDTH:0]    wr_count,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   localparam int PW = PTR_WIDTH + 1;
   localparam int unsigned DEPTH = 1 << PTR_WIDTH;
   localparam logic [PTR_WIDTH:0] AF_LEVEL = PW'(DEPTH - AF_GAP);

   logic              accept;
   logic [PTR_WIDTH:0] wr_bin;
   logic [PTR_WIDTH:0] wr_bin_next;
   logic [PTR_WIDTH:0] wr_gray_next;
   logic [PTR_WIDTH:0] rq1;
   logic [PTR_WIDTH:0] rq2;
   logic [PTR_WIDTH:0] rd_bin_sync;
   logic [PTR_WIDTH:0] occ_next;
   logic [PTR_WIDTH:0] full_pattern;

   assign accept       = wr_valid & ~full;
   assign wr_ready     = ~full;
   assign mem_wr_en    = accept;
   assign mem_wr_addr  = wr_bin[PTR_WIDTH-1:0];
   assign mem_wr_data  = wr_din;

   assign wr_bin_next  = wr_bin + PW'(accept);
   assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);

   // Full when the next write pointer equals the read pointer with its two Gray MSBs inverted.
   assign full_pattern = rq2 ^ {2'b11, {(PTR_WIDTH-1){1'b0}}};

   always_comb begin
      rd_bin_sync = '0;
      for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
         rd_bin_sync[i] = ^(rq2 >> i);
      end
   end

   assign occ_next = wr_bin_next - rd_bin_sync;

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         rq1 <= '0;
         rq2 <= '0;
      end else begin
         rq1 <= rd_ptr_gray;
         rq2 <= rq1;
      end
   end

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         wr_bin      <= '0;
         wr_ptr_gray <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_count    <= '0;
      end else begin
         wr_bin      <= wr_bin_next;
         wr_ptr_gray <= wr_gray_next;
         full        <= (wr_gray_next == full_pattern);
         almost_full <= (occ_next >= AF_LEVEL);
         wr_count    <= occ_next;
      end
   end

   // Set takes priority over clear when both happen on the same edge.
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         overflow <= 1'b0;
      end else if (wr_valid && full) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule
